// File: rtl/ssp_cfg_sync_ctrl_if.sv
// ----------------------------------------------------------------------------
// ssp_cfg_sync_ctrl_if
//   Bundles the staging-write, commit, synchronizer-handshake and status
//   signals of ssp_cfg_sync_ctrl.
//
//   master : environment side (AHB slave staging writes + config synchronizer)
//            drives wr_en/wr_sel/wr_data/commit/cfg_ready, observes the rest.
//   slave  : the controller itself.
//
//   wr_en       staging write strobe
//   wr_sel      0=DADR, 1=CADR, 2=ctrl {DBIT,DLEN}=wr_data[1:0], 3=ignored
//   wr_data     staging write data
//   commit      single-cycle request to transfer staging -> active
//   cfg_ready   synchronizer ready (already in HCLK domain)
//   cfg_req     request to synchronizer
//   DADR_O/CADR_O/DLEN_O/DBIT_O  active register set
//   busy/pending/done/timeout_err status
// ----------------------------------------------------------------------------
interface ssp_cfg_sync_ctrl_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  wr_en;
    logic [1:0]            wr_sel;
    logic [ADDR_WIDTH-1:0] wr_data;
    logic                  commit;
    logic                  cfg_ready;
    logic                  cfg_req;
    logic [ADDR_WIDTH-1:0] DADR_O;
    logic [ADDR_WIDTH-1:0] CADR_O;
    logic                  DLEN_O;
    logic                  DBIT_O;
    logic                  busy;
    logic                  pending;
    logic                  done;
    logic                  timeout_err;

    modport master (
        output wr_en, wr_sel, wr_data, commit, cfg_ready,
        input  cfg_req, DADR_O, CADR_O, DLEN_O, DBIT_O,
               busy, pending, done, timeout_err
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, commit, cfg_ready,
        output cfg_req, DADR_O, CADR_O, DLEN_O, DBIT_O,
               busy, pending, done, timeout_err
    );
endinterface

// File: rtl/ssp_cfg_sync_ctrl.sv
// ----------------------------------------------------------------------------
// ssp_cfg_sync_ctrl
//   Bus-side sequencer for the SSP/CRC configuration path. Holds a staging
//   register set written by the AHB slave; on commit copies it into the
//   active set and runs a four-phase req/ready handshake with the
//   configuration synchronizer. One commit can be queued while a handshake
//   is running; each handshake phase is guarded by a timeout.
//
//   Ports:
//     HCLK     system clock, rising edge
//     HRESETn  asynchronous active-low reset
//     bus      ssp_cfg_sync_ctrl_if.slave (staging writes, commit,
//              cfg_req/cfg_ready handshake, active outputs, status)
//
//   Parameters:
//     ADDR_WIDTH  width of DADR/CADR (>= 2, ctrl uses wr_data[1:0])
//     TIMEOUT     cycles allowed per handshake phase (>= 8)
//     CNT_WIDTH   timeout counter width, 2**CNT_WIDTH > TIMEOUT
// ----------------------------------------------------------------------------
module ssp_cfg_sync_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ssp_cfg_sync_ctrl_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_REL   = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_pending;
    logic                  r_done;
    logic                  r_terr;

    logic [ADDR_WIDTH-1:0] r_stg_dadr;
    logic [ADDR_WIDTH-1:0] r_stg_cadr;
    logic                  r_stg_dlen;
    logic                  r_stg_dbit;

    logic [ADDR_WIDTH-1:0] r_act_dadr;
    logic [ADDR_WIDTH-1:0] r_act_cadr;
    logic                  r_act_dlen;
    logic                  r_act_dbit;

    logic                  w_launch;
    logic                  w_cnt_last;

    // A launch takes either a fresh commit or the queued one; both are
    // served from the staging contents present at this edge.
    assign w_launch   = (r_state == S_IDLE) && (bus.commit || r_pending);
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // Staging set: written in any state, never touches the active set.
    // A write coinciding with a launch lands here only; the launch copies
    // the pre-write value because both read r_stg_* at the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_stg_dadr <= '0;
            r_stg_cadr <= '0;
            r_stg_dlen <= 1'b0;
            r_stg_dbit <= 1'b0;
        end else if (bus.wr_en) begin
            case (bus.wr_sel)
                2'd0: r_stg_dadr <= bus.wr_data;
                2'd1: r_stg_cadr <= bus.wr_data;
                2'd2: begin
                    r_stg_dlen <= bus.wr_data[0];
                    r_stg_dbit <= bus.wr_data[1];
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Active set: changes only on the IDLE->REQ edge, so it is already
    // stable by the time the synchronizer sees cfg_req.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_act_dadr <= '0;
            r_act_cadr <= '0;
            r_act_dlen <= 1'b0;
            r_act_dbit <= 1'b0;
        end else if (w_launch) begin
            r_act_dadr <= r_stg_dadr;
            r_act_cadr <= r_stg_cadr;
            r_act_dlen <= r_stg_dlen;
            r_act_dbit <= r_stg_dbit;
        end
    end

    // ------------------------------------------------------------------
    // Pending: any commit outside IDLE (including the REL->IDLE exit
    // cycle) is queued; repeated commits merge into the one slot.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pending <= 1'b0;
        end else if (r_state != S_IDLE) begin
            if (bus.commit)
                r_pending <= 1'b1;
        end else if (w_launch) begin
            r_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM with per-phase timeout. The counter is zeroed on
    // every phase entry, so it never needs to saturate.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_REQ;
                        r_cnt   <= '0;
                        r_terr  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (bus.cfg_ready) begin
                        r_state <= S_REL;
                        r_cnt   <= '0;
                    end else if (w_cnt_last) begin
                        r_state <= S_ABORT;
                        r_terr  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_REL: begin
                    if (!bus.cfg_ready) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_cnt_last) begin
                        r_state <= S_ABORT;
                        r_terr  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    // ABORT: wait for the synchronizer to release before
                    // accepting new work; no timeout here.
                    if (!bus.cfg_ready)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    // cfg_req decodes directly from the state register so it rises on the
    // same edge as the active-set copy and falls asynchronously on reset.
    assign bus.cfg_req     = (r_state == S_REQ);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.pending     = r_pending;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_terr;
    assign bus.DADR_O      = r_act_dadr;
    assign bus.CADR_O      = r_act_cadr;
    assign bus.DLEN_O      = r_act_dlen;
    assign bus.DBIT_O      = r_act_dbit;

endmodule

// File: tb/tb_ssp_cfg_sync_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ssp_cfg_sync_ctrl
//   Self-checking bench for ssp_cfg_sync_ctrl. Keeps a staging/active model
//   and a cycle-counting synchronizer responder; expected req/release
//   durations come from the responder's own delays.
// ----------------------------------------------------------------------------
module tb_ssp_cfg_sync_ctrl;

    localparam int AW = 6;
    localparam int TO = 64;
    localparam int VW = 2 * AW + 2;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    ssp_cfg_sync_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    ssp_cfg_sync_ctrl #(
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO),
        .CNT_WIDTH (8)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    always @(negedge HCLK) if (HRESETn && bus.done === 1'b1) done_seen++;

    // model: staging and active as {DADR, CADR, DBIT, DLEN}
    logic [AW-1:0] m_dadr, m_cadr;
    logic [1:0]    m_ctrl;
    logic [VW-1:0] m_act;

    function automatic logic [VW-1:0] stg_vec();
        return {m_dadr, m_cadr, m_ctrl};
    endfunction

    function automatic logic [VW-1:0] dut_act();
        return {bus.DADR_O, bus.CADR_O, bus.DBIT_O, bus.DLEN_O};
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [AW-1:0] d);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        case (sel)
            2'd0: m_dadr = d;
            2'd1: m_cadr = d;
            2'd2: m_ctrl = d[1:0];
            default: ;
        endcase
    endtask

    task automatic commit_launch();
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        m_act = stg_vec();
    endtask

    // Responder: raises ready in the ack-th REQ cycle, drops it in the
    // rel-th release cycle. Called while the DUT is in REQ.
    task automatic run_hs(input int ack, input int rel, input bit exit_commit,
                          input string nm);
        int rq = 0, rl = 0, bud = 0, bad = 0;
        checks++;
        if (bus.cfg_req !== 1'b1) begin
            errors++; $display("FAIL %s req_high: got %b want 1", nm, bus.cfg_req);
        end
        checks++;
        if (dut_act() !== m_act) begin
            errors++; $display("FAIL %s act_at_req: got %h want %h", nm, dut_act(), m_act);
        end
        while (bus.cfg_req === 1'b1 && bud < 500) begin
            rq++;
            if (rq >= ack) bus.cfg_ready = 1'b1;
            step(); bud++;
        end
        checks++;
        if (rq !== ack) begin
            errors++; $display("FAIL %s req_cycles: got %0d want %0d", nm, rq, ack);
        end
        while (bus.busy === 1'b1 && bud < 500) begin
            rl++;
            if (dut_act() !== m_act) bad++;
            if (rl >= rel) begin
                bus.cfg_ready = 1'b0;
                bus.commit    = exit_commit;
            end
            step(); bud++;
        end
        bus.commit = 1'b0;
        checks++;
        if (rl !== rel) begin
            errors++; $display("FAIL %s rel_cycles: got %0d want %0d", nm, rl, rel);
        end
        checks++;
        if (bad !== 0 || dut_act() !== m_act) begin
            errors++; $display("FAIL %s act_stable: got %0d unstable want 0", nm, bad);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.pending !== exit_commit) begin
            errors++; $display("FAIL %s exit: got done=%b pend=%b want 1/%b",
                               nm, bus.done, bus.pending, exit_commit);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.cfg_req, bus.busy, bus.pending, bus.done, bus.timeout_err} !== 5'b0
            || dut_act() !== '0) begin
            errors++; $display("FAIL reset_hold: got st=%b act=%h want 0/0",
                {bus.cfg_req, bus.busy, bus.pending, bus.done, bus.timeout_err}, dut_act());
        end
        HRESETn = 1'b1;
        m_dadr = '0; m_cadr = '0; m_ctrl = '0; m_act = '0;
        step();
        checks++;
        if ({bus.cfg_req, bus.busy, bus.pending, bus.done, bus.timeout_err} !== 5'b0
            || dut_act() !== '0) begin
            errors++; $display("FAIL reset_release: got st=%b act=%h want 0/0",
                {bus.cfg_req, bus.busy, bus.pending, bus.done, bus.timeout_err}, dut_act());
        end
    endtask

    task automatic test_basic();
        int d0;
        wr(2'd0, 6'h15); wr(2'd1, 6'h2A); wr(2'd2, 6'h03);
        checks++;
        if (dut_act() !== m_act) begin
            errors++; $display("FAIL basic_stage_only: got %h want %h", dut_act(), m_act);
        end
        d0 = done_seen;
        commit_launch();
        checks++;
        if (dut_act() !== {6'h15, 6'h2A, 2'b11}) begin
            errors++; $display("FAIL basic_values: got %h want %h", dut_act(), {6'h15, 6'h2A, 2'b11});
        end
        run_hs(6, 4, 1'b0, "basic");
        step();
        checks++;
        if (done_seen - d0 !== 1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL basic_end: got dones=%0d busy=%b want 1/0", done_seen - d0, bus.busy);
        end
    endtask

    task automatic test_merge();
        int d0 = done_seen;
        wr(2'd0, 6'h01);
        commit_launch();
        step(); step();
        bus.commit = 1'b1; step(); bus.commit = 1'b0;
        checks++;
        if (bus.pending !== 1'b1) begin
            errors++; $display("FAIL merge_pending: got %b want 1", bus.pending);
        end
        wr(2'd0, 6'h02);
        bus.commit = 1'b1; step(); bus.commit = 1'b0;
        run_hs(2, 2, 1'b1, "merge1");
        m_act = stg_vec();
        step();
        run_hs(3, 1, 1'b0, "merge2");
        step();
        checks++;
        if (done_seen - d0 !== 2 || bus.pending !== 1'b0 || bus.busy !== 1'b0
            || bus.DADR_O !== 6'h02) begin
            errors++; $display("FAIL merge_end: got dones=%0d pend=%b dadr=%h want 2/0/02",
                               done_seen - d0, bus.pending, bus.DADR_O);
        end
    endtask

    task automatic test_timeout_req();
        int d0 = done_seen, rq = 0;
        bus.cfg_ready = 1'b0;
        commit_launch();
        while (bus.cfg_req === 1'b1 && rq < TO + 10) begin rq++; step(); end
        checks++;
        if (rq !== TO) begin
            errors++; $display("FAIL tmo_req_cycles: got %0d want %0d", rq, TO);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b1) begin
            errors++; $display("FAIL tmo_abort: got busy=%b err=%b want 1/1", bus.busy, bus.timeout_err);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1 || done_seen !== d0) begin
            errors++; $display("FAIL tmo_idle: got busy=%b err=%b dones=%0d want 0/1/0",
                               bus.busy, bus.timeout_err, done_seen - d0);
        end
        commit_launch();
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_clear: got %b want 0", bus.timeout_err);
        end
        run_hs(1, 1, 1'b0, "tmo_recover");
        step();
    endtask

    task automatic test_timeout_rel();
        int d0 = done_seen, rq = 0, rl = 0;
        commit_launch();
        while (bus.cfg_req === 1'b1 && rq < 20) begin
            rq++;
            if (rq >= 2) bus.cfg_ready = 1'b1;
            step();
        end
        while (bus.busy === 1'b1 && bus.timeout_err === 1'b0 && rl < TO + 10) begin
            rl++; step();
        end
        checks++;
        if (rl !== TO || bus.timeout_err !== 1'b1) begin
            errors++; $display("FAIL tmo_rel_cycles: got %0d err=%b want %0d/1", rl, bus.timeout_err, TO);
        end
        repeat (3) step();
        checks++;
        if (bus.busy !== 1'b1 || bus.cfg_req !== 1'b0) begin
            errors++; $display("FAIL tmo_abort_wait: got busy=%b req=%b want 1/0", bus.busy, bus.cfg_req);
        end
        bus.cfg_ready = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || done_seen !== d0) begin
            errors++; $display("FAIL tmo_rel_exit: got busy=%b dones=%0d want 0/0", bus.busy, done_seen - d0);
        end
    endtask

    task automatic test_ready_early();
        bus.cfg_ready = 1'b1;
        step();
        commit_launch();
        run_hs(1, 5, 1'b0, "early");
        step();
    endtask

    task automatic test_commit_with_write();
        logic [VW-1:0] old;
        logic [AW-1:0] nd;
        old = stg_vec();
        nd  = ~m_dadr;
        bus.commit = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_data = nd;
        step();
        bus.commit = 1'b0; bus.wr_en = 1'b0;
        m_act = old; m_dadr = nd;
        run_hs(2, 2, 1'b0, "cw_old");
        step();
        commit_launch();
        run_hs(1, 1, 1'b0, "cw_new");
        step();
    endtask

    task automatic test_reserved_sel();
        wr(2'd3, AW'($urandom));
        checks++;
        if (dut_act() !== m_act) begin
            errors++; $display("FAIL rsv_act: got %h want %h", dut_act(), m_act);
        end
        commit_launch();
        run_hs(1, 2, 1'b0, "rsv_stage");
        step();
    endtask

    task automatic test_back_to_back();
        int d0 = done_seen;
        commit_launch();
        for (int i = 0; i < 4; i++) begin
            wr(2'($urandom_range(0, 2)), AW'($urandom));
            run_hs(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), i < 3, "b2b");
            if (i < 3) begin
                m_act = stg_vec();
                step();
            end
        end
        step();
        checks++;
        if (done_seen - d0 !== 4 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_dones: got %0d busy=%b want 4/0", done_seen - d0, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        commit_launch();
        step();
        bus.commit = 1'b1; step(); bus.commit = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if ({bus.cfg_req, bus.busy, bus.pending, bus.done, bus.timeout_err} !== 5'b0
            || dut_act() !== '0) begin
            errors++; $display("FAIL rst_mid_async: got st=%b act=%h want 0/0",
                {bus.cfg_req, bus.busy, bus.pending, bus.done, bus.timeout_err}, dut_act());
        end
        step();
        HRESETn = 1'b1;
        m_dadr = '0; m_cadr = '0; m_ctrl = '0; m_act = '0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.pending !== 1'b0) begin
            errors++; $display("FAIL rst_mid_lost: got busy=%b pend=%b want 0/0", bus.busy, bus.pending);
        end
        wr(2'd0, 6'h33);
        commit_launch();
        run_hs(2, 2, 1'b0, "rst_after");
        step();
    endtask

    task automatic test_random();
        int d0;
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(1, 4)) wr(2'($urandom_range(0, 3)), AW'($urandom));
            d0 = done_seen;
            commit_launch();
            run_hs(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), 1'b0, "rand");
            step();
            checks++;
            if (done_seen - d0 !== 1) begin
                errors++; $display("FAIL rand_done: got %0d want 1", done_seen - d0);
            end
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = 2'd0; bus.wr_data = '0;
        bus.commit = 1'b0; bus.cfg_ready = 1'b0;
        test_reset();
        test_basic();
        test_merge();
        test_timeout_req();
        test_timeout_rel();
        test_ready_early();
        test_commit_with_write();
        test_reserved_sel();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssp_cfg_sync_ctrl.md
Name: ssp_cfg_sync_ctrl

Overview:
- Bus-side sequencer for the SSP/CRC configuration path. It holds a staging register set (DADR, CADR, DLEN, DBIT) written by the AHB slave.
- On commit, it copies the staging set into an active set, then runs a four-phase req/ready handshake with the configuration synchronizer.
- It queues one pending commit, times out stalled handshakes, and reports status.

Parameters:
- ADDR_WIDTH, 6, width of DADR/CADR fields.
- TIMEOUT, 64, HCLK cycles allowed per handshake phase before abort; must be >= 8.
- CNT_WIDTH, 8, timeout counter width; requires 2^CNT_WIDTH > TIMEOUT.

Ports:
- HCLK  in  1  system clock, all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- wr_en  in  1  staging write strobe, one-cycle qualifier.
- wr_sel  in  2  0=DADR, 1=CADR, 2=ctrl {DBIT,DLEN} in bits[1:0], 3=reserved (ignored).
- wr_data  in  ADDR_WIDTH  write data.
- commit  in  1  single-cycle request to transfer staging set.
- cfg_ready  in  1  synchronizer's returned ready (REGs_ready), already in HCLK domain.
- cfg_req  out  1  request to synchronizer.
- DADR_O  out  ADDR_WIDTH  active DADR.
- CADR_O  out  ADDR_WIDTH  active CADR.
- DLEN_O  out  1  active DLEN.
- DBIT_O  out  1  active DBIT.
- busy  out  1  handshake in progress (state != IDLE).
- pending  out  1  a commit is queued.
- done  out  1  one-cycle pulse on successful handshake completion.
- timeout_err  out  1  sticky; set on abort, cleared by next accepted commit.

Behaviour:
- Reset values (async, HRESETn low): all staging and active registers 0; cfg_req, busy, pending, done and timeout_err all 0; state IDLE; counter 0.
- Staging writes: wr_en updates the field selected by wr_sel at the next edge, in any state. Staging writes never disturb the active outputs.
- State IDLE:
  - If commit or pending is set, copy staging to active and clear pending.
  - Also clear timeout_err, zero the counter, and go to REQ.
  - cfg_req rises in the same edge as the copy, so the active outputs are stable when req is seen.
- State REQ: cfg_req=1.
  - If cfg_ready=1, go to REL and zero the counter.
  - Else if counter==TIMEOUT-1, go to ABORT.
  - Else increment the counter.
- State REL: cfg_req=0.
  - If cfg_ready=0, pulse done for one cycle and go to IDLE.
  - Else if counter==TIMEOUT-1, go to ABORT.
  - Else increment the counter.
- State ABORT: cfg_req=0. Set timeout_err, then wait for cfg_ready=0 before going to IDLE; no timeout applies here. done is not pulsed.
- Commit arbitration:
  - commit while busy sets pending; further commits while pending are merged, and the staging contents current at launch are used.
  - commit in the same cycle as the REL->IDLE exit sets pending; IDLE then launches it on the following cycle.
  - commit in the same cycle as wr_en in IDLE launches with the pre-write staging value. The write lands in staging only.
- Outputs: active registers change only on the IDLE->REQ edge. They are held stable through REQ, REL and ABORT.
- Minimum cycle: IDLE->REQ, REQ->REL and REL->IDLE are one edge each when ready responds immediately, so back-to-back launches are separated by at least 1 IDLE cycle.
- Counter: saturating logic is not needed, since the counter is zeroed at every phase entry.
- Reset mid-operation: immediate return to reset values. Any queued commit is lost. cfg_req drops asynchronously.

Test Plan:
- Write DADR=0x15, CADR=0x2A, ctrl=2'b11, then commit with a synchronizer model asserting ready 5 cycles after req and dropping it 4 cycles after release.
  - Required: outputs read 0x15/0x2A/1/1 from the req edge, req is high for 6 cycles, done pulses once, busy clears.
- Issue commit twice while busy, changing DADR 0x01->0x02 between them.
  - Required: pending=1, a single second handshake follows with DADR_O=0x02, and two done pulses in total.
- Hold cfg_ready=0 forever after commit.
  - Required: req drops after TIMEOUT=64 cycles, timeout_err=1, no done pulse; the next commit clears timeout_err.
- Assert cfg_ready before commit, held high.
  - Required: REQ->REL occurs on the first REQ cycle, and done waits until ready falls.
- Pulse HRESETn low during REQ.
  - Required: cfg_req, busy, pending and all outputs go to 0 immediately without waiting for HCLK; post-reset commit works normally.
- Stage a write with wr_sel=3.
  - Required: no register changes.
